// File: rtl/req_arbiter_83_if.sv
// Requester/resource handshake bundle for the 8-way arbiter.
// master: requester side (drives req/done). slave: arbiter side (drives grant outputs).
interface req_arbiter_83_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/req_arbiter_83.sv
// 8-requester arbiter with a registered one-hot grant and a hold timeout.
// The grant is held until the owner pulses done, drops its request, or
// has held the resource for MAX_HOLD cycles. Selection is either fixed
// priority (highest index wins) or rotating, starting just below the last owner.
module req_arbiter_83 #(
    parameter int unsigned MAX_HOLD    = 16,
    parameter int unsigned ROUND_ROBIN = 0
) (
    input  logic              clk,
    input  logic              rst,
    req_arbiter_83_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q,     state_d;
    logic [7:0] gnt_q,       gnt_d;
    logic [2:0] gnt_id_q,    gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q,   timeout_d;
    logic [7:0] hold_cnt_q,  hold_cnt_d;
    logic [2:0] last_id_q,   last_id_d;

    logic [2:0] scan_start_s;
    logic [2:0] scan_idx_s;
    logic [2:0] win_id_s;
    logic       win_found_s;

    // Winner search: scan downward from the start index, first bit that is
    // definitely 1 wins. Unknown bits never match, so gnt stays 0 or one-hot.
    always_comb begin
        scan_idx_s  = 3'd0;
        win_id_s    = 3'd0;
        win_found_s = 1'b0;
        if (ROUND_ROBIN != 0) begin
            scan_start_s = last_id_q - 3'd1;
        end else begin
            scan_start_s = 3'd7;
        end
        for (int k = 0; k < 8; k++) begin
            scan_idx_s = scan_start_s - 3'(k);
            if (!win_found_s && (bus.req[scan_idx_s] == 1'b1)) begin
                win_found_s = 1'b1;
                win_id_s    = scan_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and grant logic; release precedence is done/drop, then timeout.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    state_d     = BUSY;
                    gnt_d       = 8'd1 << win_id_s;
                    gnt_id_d    = win_id_s;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd0;
                    last_id_d   = win_id_s;
                end else begin
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                end
            end
            BUSY: begin
                if ((bus.done == 1'b1) || (bus.req[gnt_id_q] != 1'b1)) begin
                    state_d     = IDLE;
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = IDLE;
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 8'd0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears outputs at once with no timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= 8'd0;
            last_id_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter_83.sv
// Directed bench: a fixed-priority and a round-robin instance, MAX_HOLD=16.
module tb_req_arbiter_83;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    req_arbiter_83_if fx ();
    req_arbiter_83_if rr ();

    req_arbiter_83 #(.MAX_HOLD(16), .ROUND_ROBIN(0)) u_fix (
        .clk (clk),
        .rst (rst),
        .bus (fx)
    );

    req_arbiter_83 #(.MAX_HOLD(16), .ROUND_ROBIN(1)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] exp_id;
        logic       held_ok;
        checks = 0;
        errors = 0;
        rst     = 1'b1;
        fx.req  = 8'h00;
        fx.done = 1'b0;
        rr.req  = 8'h00;
        rr.done = 1'b0;
        tick();
        tick();
        check("rst_gnt",     32'(fx.gnt),       32'h00);
        check("rst_gnt_id",  32'(fx.gnt_id),    32'h0);
        check("rst_valid",   32'(fx.gnt_valid), 32'h0);
        check("rst_timeout", 32'(fx.timeout),   32'h0);
        rst = 1'b0;
        tick();
        check("idle_no_req", 32'(fx.gnt), 32'h00);

        // Fixed priority: highest set bit wins, latency one cycle
        fx.req = 8'b1010_0100;
        tick();
        check("fix_gnt",    32'(fx.gnt),       32'h80);
        check("fix_gnt_id", 32'(fx.gnt_id),    32'h7);
        check("fix_valid",  32'(fx.gnt_valid), 32'h1);

        // Release by done at hold_cnt=3, one idle cycle, then regrant to 5
        tick();
        tick();
        tick();
        check("hold_before_done", 32'(fx.gnt), 32'h80);
        fx.done = 1'b1;
        fx.req  = 8'h24;
        tick();
        fx.done = 1'b0;
        check("rel_gnt",     32'(fx.gnt),       32'h00);
        check("rel_valid",   32'(fx.gnt_valid), 32'h0);
        check("rel_id_kept", 32'(fx.gnt_id),    32'h7);
        check("rel_timeout", 32'(fx.timeout),   32'h0);
        tick();
        check("regrant_gnt", 32'(fx.gnt),    32'h20);
        check("regrant_id",  32'(fx.gnt_id), 32'h5);

        // Owner drops its request -> release; then a fresh grant to 3
        fx.req = 8'h08;
        tick();
        check("drop_rel", 32'(fx.gnt), 32'h00);
        tick();
        check("to_grant", 32'(fx.gnt), 32'h08);

        // Timeout: held 16 cycles total, then revoked with a 1-cycle pulse
        held_ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if ((fx.gnt !== 8'h08) || (fx.timeout !== 1'b0)) held_ok = 1'b0;
        end
        check("to_held_15", 32'(held_ok), 32'h1);
        tick();
        check("to_rel_gnt",   32'(fx.gnt),     32'h00);
        check("to_pulse",     32'(fx.timeout), 32'h1);
        tick();
        check("to_regrant",   32'(fx.gnt),     32'h08);
        check("to_pulse_end", 32'(fx.timeout), 32'h0);

        // done on the last allowed cycle wins over the timeout
        for (int i = 0; i < 15; i++) tick();
        check("sim_still_held", 32'(fx.gnt), 32'h08);
        fx.done = 1'b1;
        tick();
        fx.done = 1'b0;
        check("sim_gnt",     32'(fx.gnt),     32'h00);
        check("sim_timeout", 32'(fx.timeout), 32'h0);
        tick();
        check("sim_regrant", 32'(fx.gnt), 32'h08);

        // Request dropped alone -> release next edge, then stay idle
        fx.req = 8'h00;
        tick();
        check("drop_alone_gnt",   32'(fx.gnt),       32'h00);
        check("drop_alone_valid", 32'(fx.gnt_valid), 32'h0);
        tick();
        check("idle_stays", 32'(fx.gnt), 32'h00);

        // No preemption by a higher-priority request while busy
        fx.req = 8'h01;
        tick();
        check("low_grant", 32'(fx.gnt), 32'h01);
        fx.req = 8'h81;
        tick();
        check("no_preempt",    32'(fx.gnt),    32'h01);
        check("no_preempt_id", 32'(fx.gnt_id), 32'h0);
        fx.req = 8'h80;
        tick();
        check("preempt_rel", 32'(fx.gnt), 32'h00);
        tick();
        check("high_grant", 32'(fx.gnt), 32'h80);

        // Async reset between edges clears outputs immediately
        #2;
        rst = 1'b1;
        #1;
        check("arst_gnt",   32'(fx.gnt),       32'h00);
        check("arst_valid", 32'(fx.gnt_valid), 32'h0);
        check("arst_to",    32'(fx.timeout),   32'h0);
        fx.req = 8'h01;
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_gnt", 32'(fx.gnt),    32'h01);
        check("post_rst_id",  32'(fx.gnt_id), 32'h0);

        // Unknown request bits in IDLE must never give a multi-hot or unknown grant
        fx.req = 8'h00;
        tick();
        fx.req = 8'bx0x0_0x00;
        tick();
        check("x_known",  32'($isunknown(fx.gnt)),        32'h0);
        check("x_onehot", 32'($countones(fx.gnt) <= 1),   32'h1);
        fx.req = 8'h00;
        tick();
        tick();

        // Round robin: all requesting, done after each grant -> 7,6,...,0,7
        rr.req = 8'hFF;
        exp_id = 3'd7;
        for (int g = 0; g < 9; g++) begin
            tick();
            check("rr_id",  32'(rr.gnt_id), 32'(exp_id));
            check("rr_gnt", 32'(rr.gnt),    32'(8'd1 << exp_id));
            rr.done = 1'b1;
            tick();
            rr.done = 1'b0;
            exp_id = exp_id - 3'd1;
        end
        check("rr_idle", 32'(rr.gnt), 32'h00);

        // Round robin: after owner 7, scan starts at 6 -> requester 3 beats 0
        rr.req = 8'h09;
        tick();
        check("rr_skip_id", 32'(rr.gnt_id), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
